social_scene_driver: RTL and testbench
======================================

// Module: social_scene_driver
// PURPOSE
//  Drives the social-situation inputs of the introvert mood FSM (known_people/unknown_people/comfort_zone)
//  from a queued stream of scene requests, then reads the FSM's 2-bit mood output back and confirms it.
//  Sits on the opposite end of the mood interface: upstream sequencer -> this block -> mood FSM -> mood_in.
//  Scene code equals expected mood code: 00 known->happy, 01 unknown->awkward, 10 comfort->very_happy.
// PARAMETERS
//  DEPTH    4  request queue entries (power of 2, >=2)
//  DWELL    3  cycles a scene line is held asserted (>=1)
//  TIMEOUT  8  cycles in CHECK waiting for mood_in to match before flagging mismatch (>=1)
// PORTS
//  clk             in   1  single clock, rising edge
//  reset           in   1  asynchronous, active-high; clears everything
//  req_valid       in   1  scene request valid
//  req_scene       in   2  requested scene code (11 = illegal)
//  req_ready       out  1  = !queue_full
//  mood_in         in   2  mood code read back from the mood FSM
//  known_people    out  1  one-hot scene drive (registered)
//  unknown_people  out  1  one-hot scene drive (registered)
//  comfort_zone    out  1  one-hot scene drive (registered)
//  busy            out  1  FSM not IDLE or queue not empty
//  done_pulse      out  1  1-cycle: mood confirmed for current scene
//  mismatch_pulse  out  1  1-cycle: TIMEOUT expired without match
//  err_cnt         out  8  saturating count of mismatches + illegal requests
// BEHAVIOUR
//  Reset (async): queue empty, FSM IDLE, all three drive lines 0, pulses 0, err_cnt 0, req_ready 1.
//  Reset asserted mid-DRIVE/CHECK: lines drop immediately, queued scenes lost, no pulse emitted.
//  Handshake: push when req_valid && req_ready. Full queue: req_ready=0 even if a pop occurs that cycle.
//  Illegal scene 11: handshake completes, entry NOT queued, err_cnt+1 next cycle, no pulse.
//  FSM IDLE -> DRIVE: queue non-empty; head popped, latched as cur_scene.
//  DRIVE: exactly the one line for cur_scene is 1 for DWELL consecutive cycles, others 0. Never >1 high.
//  DRIVE -> CHECK after DWELL cycles; all lines 0 in CHECK.
//  CHECK: mood_in==cur_scene -> done_pulse next cycle, -> IDLE.
//    Else after TIMEOUT cycles -> mismatch_pulse next cycle, err_cnt+1, -> IDLE.
//  Back-to-back: with queue non-empty, IDLE lasts exactly 1 cycle between scenes.
//  err_cnt saturates at 8'hFF; illegal push and mismatch in the same cycle add 2 (saturating).
//  Queue pointers wrap modulo DEPTH; occupancy counter width $clog2(DEPTH+1).
//  Pop-to-line latency: line asserted in the cycle after the pop (registered outputs).
// CONFIGURATION
//  `SKIP_SAME_MOOD_EN defined: at pop, if mood_in already equals the popped scene, skip DRIVE/CHECK;
//    done_pulse next cycle, FSM stays IDLE, no line asserted.
//  Not defined: every legal scene is driven for DWELL cycles and checked, whatever the current mood.
// STRUCTURE
//  Shared package social_pkg: scene/mood codes HAPPY=2'b00, AWKWARD=2'b01, VERY_HAPPY=2'b10,
//    ILLEGAL=2'b11; FSM state encoding IDLE/DRIVE/CHECK.
//  Sub-module scene_fifo (DEPTH x 2-bit, push/pop/full/empty, async reset); FSM + counters in top.
// TESTING
//  Reset: push 3 scenes, assert reset mid-DRIVE -> lines 0 same cycle, req_ready=1, err_cnt=0, busy=0.
//  Single scene 01, model echoes mood 01 after 1 cycle -> unknown_people high 3 cycles, done_pulse once, err_cnt 0.
//  Scene 10, mood_in stuck at 00 -> comfort_zone 3 cycles, mismatch_pulse 8 cycles later, err_cnt=1.
//  Burst 5 pushes with DEPTH=4 and no pops -> 5th stalls (req_ready=0); scenes driven in FIFO order 00,01,10,00,01.
//  Push 11 -> req_ready stays 1, nothing driven, err_cnt=1; 300 forced mismatches -> err_cnt holds 8'hFF.
//  SKIP_SAME_MOOD_EN: mood_in=00, push 00 -> no line asserted, done_pulse 1 cycle after pop; macro off -> known_people 3 cycles.

Source files
------------

// File: rtl/social_pkg.sv
// Shared scene/mood codes and driver FSM state encoding for the social scene driver.
package social_pkg;

    typedef enum logic [1:0] {
        HAPPY      = 2'b00,
        AWKWARD    = 2'b01,
        VERY_HAPPY = 2'b10,
        ILLEGAL    = 2'b11
    } scene_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        CHECK = 2'b10
    } state_e;

    // Line vector order is {comfort_zone, unknown_people, known_people}.
    function automatic logic [2:0] scene_lines(input logic [1:0] scene);
        logic [2:0] lines;
        lines = 3'b000;
        case (scene)
            HAPPY:      lines = 3'b001;
            AWKWARD:    lines = 3'b010;
            VERY_HAPPY: lines = 3'b100;
            default:    lines = 3'b000;
        endcase
        return lines;
    endfunction

endpackage

// File: rtl/scene_fifo.sv
// DEPTH x 2-bit scene request queue with wrapping pointers and an occupancy counter.
module scene_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [1:0] push_data,
    input  logic       pop,
    output logic [1:0] head,
    output logic       full,
    output logic       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]    mem_q [DEPTH];
    logic [1:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/social_scene_driver.sv
// Drives one social-situation line per queued scene and confirms the mood FSM's answer.
// Optional feature macro: SKIP_SAME_MOOD_EN (confirm without driving when the mood already matches).
module social_scene_driver
    import social_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DWELL   = 3,
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_scene,
    output logic       req_ready,
    input  logic [1:0] mood_in,
    output logic       known_people,
    output logic       unknown_people,
    output logic       comfort_zone,
    output logic       busy,
    output logic       done_pulse,
    output logic       mismatch_pulse,
    output logic [7:0] err_cnt
);

    localparam int CNT_MAX = (DWELL > TIMEOUT) ? DWELL : TIMEOUT;
    localparam int CNTW    = $clog2(CNT_MAX + 1);

    state_e          state_q, state_d;
    logic [1:0]      cur_scene_q, cur_scene_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [2:0]      lines_q, lines_d;
    logic            done_q, done_d;
    logic            mismatch_q, mismatch_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [8:0]      err_sum;

    logic            accept;
    logic            illegal_push;
    logic            fifo_push;
    logic            fifo_pop;
    logic [1:0]      fifo_head;
    logic            fifo_full;
    logic            fifo_empty;

    assign req_ready    = !fifo_full;
    assign accept       = req_valid && req_ready;
    assign illegal_push = accept && (req_scene == ILLEGAL);
    assign fifo_push    = accept && (req_scene != ILLEGAL);

    scene_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_data(req_scene),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Lines are registered, so the line for a popped scene rises the cycle after the pop.
    always_comb begin
        state_d     = state_q;
        cur_scene_d = cur_scene_q;
        cnt_d       = cnt_q;
        lines_d     = 3'b000;
        done_d      = 1'b0;
        mismatch_d  = 1'b0;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    cur_scene_d = fifo_head;
                    cnt_d       = '0;
`ifdef SKIP_SAME_MOOD_EN
                    if (mood_in == fifo_head) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = DRIVE;
                        lines_d = scene_lines(fifo_head);
                    end
`else
                    state_d = DRIVE;
                    lines_d = scene_lines(fifo_head);
`endif
                end
            end
            DRIVE: begin
                if (cnt_q == CNTW'(DWELL - 1)) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    lines_d = scene_lines(cur_scene_q);
                end
            end
            CHECK: begin
                if (mood_in == cur_scene_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    mismatch_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // An illegal push and a timeout in the same cycle both count; the total clamps at 8'hFF.
    always_comb begin
        err_sum   = {1'b0, err_cnt_q} + 9'(illegal_push) + 9'(mismatch_d);
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_scene_q <= 2'b00;
            cnt_q       <= '0;
            lines_q     <= 3'b000;
            done_q      <= 1'b0;
            mismatch_q  <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            cur_scene_q <= cur_scene_d;
            cnt_q       <= cnt_d;
            lines_q     <= lines_d;
            done_q      <= done_d;
            mismatch_q  <= mismatch_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign known_people   = lines_q[0];
    assign unknown_people = lines_q[1];
    assign comfort_zone   = lines_q[2];
    assign done_pulse     = done_q;
    assign mismatch_pulse = mismatch_q;
    assign err_cnt        = err_cnt_q;
    assign busy           = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_social_scene_driver.sv
// Scoreboard bench for social_scene_driver with a simple mood FSM model (echo or stuck mood).
// Expected scene runs and pulse types are queued at push time and matched against observed runs.
module tb_social_scene_driver;

    localparam int DEPTH   = 4;
    localparam int DWELL   = 3;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_scene;
    logic       req_ready;
    logic [1:0] mood_in;
    logic       known_people;
    logic       unknown_people;
    logic       comfort_zone;
    logic       busy;
    logic       done_pulse;
    logic       mismatch_pulse;
    logic [7:0] err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0] scene;
        int         len;
        int         end_cyc;
    } run_t;

    run_t       obs_runs[$];
    int         obs_pulses[$];
    int         pulse_cyc[$];
    logic [1:0] exp_scenes[$];
    int         exp_pulses[$];
    int         cyc       = 0;
    int         run_len   = 0;
    logic [1:0] run_scene = 2'b00;
    int         multi_hot = 0;

    logic       mood_echo  = 1'b0;
    logic [1:0] mood_force = 2'b11;

    always #5 clk = ~clk;

    social_scene_driver #(
        .DEPTH  (DEPTH),
        .DWELL  (DWELL),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_scene     (req_scene),
        .req_ready     (req_ready),
        .mood_in       (mood_in),
        .known_people  (known_people),
        .unknown_people(unknown_people),
        .comfort_zone  (comfort_zone),
        .busy          (busy),
        .done_pulse    (done_pulse),
        .mismatch_pulse(mismatch_pulse),
        .err_cnt       (err_cnt)
    );

    // Mood FSM stand-in: either follows the active line one cycle later or holds a forced mood.
    always @(posedge clk) begin
        if (!mood_echo)          mood_in <= mood_force;
        else if (known_people)   mood_in <= 2'b00;
        else if (unknown_people) mood_in <= 2'b01;
        else if (comfort_zone)   mood_in <= 2'b10;
    end

    task automatic tick();
        logic [2:0] lines;
        run_t       r;
        @(posedge clk);
        #1;
        cyc++;
        lines = {comfort_zone, unknown_people, known_people};
        if ($countones(lines) > 1) multi_hot++;
        if (lines != 3'b000) begin
            if (run_len == 0) run_scene = known_people ? 2'b00 : (unknown_people ? 2'b01 : 2'b10);
            run_len++;
        end else if (run_len > 0) begin
            r.scene   = run_scene;
            r.len     = run_len;
            r.end_cyc = cyc;
            obs_runs.push_back(r);
            run_len = 0;
        end
        if (done_pulse) begin
            obs_pulses.push_back(0);
            pulse_cyc.push_back(cyc);
        end
        if (mismatch_pulse) begin
            obs_pulses.push_back(1);
            pulse_cyc.push_back(cyc);
        end
    endtask

    task automatic clear_sb();
        obs_runs.delete();
        obs_pulses.delete();
        pulse_cyc.delete();
        exp_scenes.delete();
        exp_pulses.delete();
        run_len   = 0;
        multi_hot = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        clear_sb();
    endtask

    task automatic set_mood(input logic [1:0] m, input logic echo_after);
        mood_echo  = 1'b0;
        mood_force = m;
        tick();
        mood_echo = echo_after;
    endtask

    task automatic push_scene(input logic [1:0] s, input bit track);
        int n = 0;
        req_valid = 1'b1;
        req_scene = s;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (req_ready) begin
            tick();
            if (track && s != 2'b11) exp_scenes.push_back(s);
        end else begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL push_timeout: req_ready stayed %b for %0d cycles, required 1", req_ready, n);
        end
        req_valid = 1'b0;
        req_scene = 2'b00;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", tag, busy, budget);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        int n = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_scene = 2'b00;
        #1;
        vectors++;
        if ({known_people, unknown_people, comfort_zone, done_pulse, mismatch_pulse, busy, req_ready, err_cnt} !== {7'b0000001, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL reset_state: lines=%b%b%b done=%b mism=%b busy=%b ready=%b err=%h, required all 0 except ready=1",
                     comfort_zone, unknown_people, known_people, done_pulse, mismatch_pulse, busy, req_ready, err_cnt);
        end
        tick();
        tick();
        reset = 1'b0;
        clear_sb();
        push_scene(2'b01, 0);
        push_scene(2'b10, 0);
        push_scene(2'b00, 0);
        while (!(known_people || unknown_people || comfort_zone) && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("[TB] FAIL reset_drive_seen: no line asserted in %0d cycles, required a DRIVE", n);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({comfort_zone, unknown_people, known_people} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_lines_drop: lines=%b, required 000", {comfort_zone, unknown_people, known_people});
        end
        vectors++;
        if ({req_ready, busy, err_cnt} !== {1'b1, 1'b0, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_drive: ready=%b busy=%b err=%h, required 1 0 00", req_ready, busy, err_cnt);
        end
        #3;
        reset = 1'b0;
        clear_sb();
        repeat (10) tick();
        vectors++;
        if (obs_runs.size() != 0 || obs_pulses.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_queue_lost: runs=%0d pulses=%0d busy=%b, required 0 0 0", obs_runs.size(), obs_pulses.size(), busy);
        end
        clear_sb();
    endtask

    task automatic test_single_scene();
        logic [1:0] e;
        run_t       r;
        int         p;
        do_reset();
        set_mood(2'b11, 1'b1);
        push_scene(2'b01, 1);
        exp_pulses.push_back(0);
        wait_idle(50, "single");
        vectors++;
        if (obs_runs.size() != exp_scenes.size() || obs_pulses.size() != exp_pulses.size()) begin
            miscompares++;
            $display("[TB] FAIL single_counts: runs=%0d pulses=%0d, required %0d %0d", obs_runs.size(), obs_pulses.size(), exp_scenes.size(), exp_pulses.size());
        end
        while (exp_scenes.size() > 0 && obs_runs.size() > 0 && obs_pulses.size() > 0) begin
            e = exp_scenes.pop_front();
            r = obs_runs.pop_front();
            vectors++;
            if (r.scene !== e || r.len != DWELL) begin
                miscompares++;
                $display("[TB] FAIL single_run: scene=%b len=%0d, required scene=%b len=%0d", r.scene, r.len, e, DWELL);
            end
            p = pulse_cyc.pop_front();
            vectors++;
            if (obs_pulses.pop_front() != exp_pulses.pop_front() || p - r.end_cyc != 1) begin
                miscompares++;
                $display("[TB] FAIL single_done: pulse delay %0d or wrong type, required done after 1 cycle", p - r.end_cyc);
            end
        end
        vectors++;
        if (err_cnt !== 8'h00 || multi_hot != 0) begin
            miscompares++;
            $display("[TB] FAIL single_err: err=%h multi_hot=%0d, required 00 0", err_cnt, multi_hot);
        end
        clear_sb();
    endtask

    task automatic test_mismatch();
        logic [1:0] e;
        run_t       r;
        int         p;
        do_reset();
        set_mood(2'b00, 1'b0);
        push_scene(2'b10, 1);
        exp_pulses.push_back(1);
        wait_idle(60, "mismatch");
        vectors++;
        if (obs_runs.size() != 1 || obs_pulses.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL mismatch_counts: runs=%0d pulses=%0d, required 1 1", obs_runs.size(), obs_pulses.size());
        end
        if (obs_runs.size() > 0 && obs_pulses.size() > 0) begin
            e = exp_scenes.pop_front();
            r = obs_runs.pop_front();
            vectors++;
            if (r.scene !== e || r.len != DWELL) begin
                miscompares++;
                $display("[TB] FAIL mismatch_run: scene=%b len=%0d, required scene=%b len=%0d", r.scene, r.len, e, DWELL);
            end
            p = pulse_cyc.pop_front();
            vectors++;
            if (obs_pulses.pop_front() != exp_pulses.pop_front() || p - r.end_cyc != TIMEOUT) begin
                miscompares++;
                $display("[TB] FAIL mismatch_pulse: delay=%0d or wrong type, required mismatch after %0d cycles", p - r.end_cyc, TIMEOUT);
            end
        end
        vectors++;
        if (err_cnt !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL mismatch_err: err=%h, required 01", err_cnt);
        end
        clear_sb();
    endtask

    task automatic test_back_to_back();
        logic [1:0] order[5];
        logic [1:0] e;
        run_t       r;
        order = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
        do_reset();
        set_mood(2'b11, 1'b1);
        for (int i = 0; i < 5; i++) begin
            push_scene(order[i], 1);
            exp_pulses.push_back(0);
        end
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL burst_full: req_ready=%b, required 0", req_ready);
        end
        tick();
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL burst_full_pop: req_ready=%b during pop cycle, required 0", req_ready);
        end
        wait_idle(200, "burst");
        vectors++;
        if (obs_runs.size() != 5 || obs_pulses.size() != 5) begin
            miscompares++;
            $display("[TB] FAIL burst_counts: runs=%0d pulses=%0d, required 5 5", obs_runs.size(), obs_pulses.size());
        end
        while (exp_scenes.size() > 0 && obs_runs.size() > 0) begin
            e = exp_scenes.pop_front();
            r = obs_runs.pop_front();
            vectors++;
            if (r.scene !== e || r.len != DWELL) begin
                miscompares++;
                $display("[TB] FAIL burst_order: scene=%b len=%0d, required scene=%b len=%0d", r.scene, r.len, e, DWELL);
            end
        end
        while (exp_pulses.size() > 0 && obs_pulses.size() > 0) begin
            vectors++;
            if (obs_pulses.pop_front() != exp_pulses.pop_front()) begin
                miscompares++;
                $display("[TB] FAIL burst_pulse: mismatch pulse seen, required done");
            end
        end
        vectors++;
        if (err_cnt !== 8'h00 || multi_hot != 0) begin
            miscompares++;
            $display("[TB] FAIL burst_err: err=%h multi_hot=%0d, required 00 0", err_cnt, multi_hot);
        end
        clear_sb();
    endtask

    task automatic test_illegal_saturate();
        do_reset();
        set_mood(2'b00, 1'b0);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL illegal_ready_before: req_ready=%b, required 1", req_ready);
        end
        push_scene(2'b11, 1);
        vectors++;
        if (err_cnt !== 8'h01 || req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL illegal_err: err=%h ready=%b, required 01 1", err_cnt, req_ready);
        end
        repeat (10) tick();
        vectors++;
        if (obs_runs.size() != 0 || obs_pulses.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL illegal_not_queued: runs=%0d pulses=%0d busy=%b, required 0 0 0", obs_runs.size(), obs_pulses.size(), busy);
        end
        for (int i = 0; i < 300; i++) begin
            push_scene(2'b01, 0);
        end
        wait_idle(200, "saturate");
        vectors++;
        if (err_cnt !== 8'hFF) begin
            miscompares++;
            $display("[TB] FAIL saturate_err: err=%h, required FF", err_cnt);
        end
        push_scene(2'b11, 0);
        tick();
        vectors++;
        if (err_cnt !== 8'hFF) begin
            miscompares++;
            $display("[TB] FAIL saturate_hold: err=%h, required FF", err_cnt);
        end
        clear_sb();
    endtask

    task automatic test_skip_same_mood();
        int   push_cyc;
        run_t r;
        do_reset();
        set_mood(2'b00, 1'b0);
        push_scene(2'b00, 1);
        push_cyc = cyc;
        wait_idle(50, "skip");
        vectors++;
        if (obs_pulses.size() != 1 || obs_pulses[0] != 0) begin
            miscompares++;
            $display("[TB] FAIL skip_done_count: pulses=%0d, required exactly 1 done", obs_pulses.size());
        end
`ifdef SKIP_SAME_MOOD_EN
        vectors++;
        if (obs_runs.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL skip_no_line: runs=%0d, required 0", obs_runs.size());
        end
        vectors++;
        if (pulse_cyc.size() > 0 && pulse_cyc[0] - push_cyc != 1) begin
            miscompares++;
            $display("[TB] FAIL skip_latency: done %0d cycles after pop, required 1", pulse_cyc[0] - push_cyc);
        end
`else
        vectors++;
        if (obs_runs.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL noskip_runs: runs=%0d, required 1", obs_runs.size());
        end else begin
            r = obs_runs[0];
            vectors++;
            if (r.scene !== 2'b00 || r.len != DWELL || r.end_cyc - push_cyc != DWELL + 1) begin
                miscompares++;
                $display("[TB] FAIL noskip_known: scene=%b len=%0d end=%0d, required 00 %0d %0d",
                         r.scene, r.len, r.end_cyc - push_cyc, DWELL, DWELL + 1);
            end
        end
`endif
        clear_sb();
    endtask

    initial begin
        test_reset();
        test_single_scene();
        test_mismatch();
        test_back_to_back();
        test_illegal_saturate();
        test_skip_same_mood();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
